hermes_vc_crossbar: RTL and testbench

- Registered, credit-based crossbar for the Hermes router generation with virtual channels.
- Connects NPORT*NVC input channels (port, VC) to NPORT output ports.
- Connections come from the external switch allocator. Per-output, per-VC credit counters track downstream buffer space, and each output has one registered stage.
- Sits between the input buffers/allocator and the link interfaces.

---
 rtl/hermes_pkg.sv | 17 +
 rtl/hermes_credit_counter.sv | 21 ++
 rtl/hermes_vc_crossbar.sv | 60 ++++++
 tb/tb_hermes_vc_crossbar.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hermes_pkg.sv
// hermes_pkg: shared sizes, flit type and port indices for the Hermes VC router
package hermes_pkg;
  localparam int FLIT_SIZE = 32;
  localparam int NPORT = 5;
  localparam int NVC = 2;
  localparam int CREDITS = 4;
  localparam int NCH = NPORT * NVC;
  localparam int CH_W = $clog2(NCH);
  localparam int VC_W = NVC > 1 ? $clog2(NVC) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int EAST = 0;
  localparam int WEST = 1;
  localparam int NORTH = 2;
  localparam int SOUTH = 3;
  localparam int LOCAL = 4;
  typedef logic [FLIT_SIZE-1:0] flit_t;
endpackage

// File: rtl/hermes_credit_counter.sv
// hermes_credit_counter: saturating up/down credit count for one (output, VC) pair
module hermes_credit_counter
  import hermes_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);
  assign nonzero = count != '0;
  always_ff @(posedge clk_i)
    if (rst_i) count <= FULL;
    else if (inc && !dec && count != FULL) count <= count + CNT_W'(1);
    else if (dec && !inc) count <= count - CNT_W'(1);
  always_ff @(posedge clk_i)
    if (!rst_i && inc && !dec)
      assert (count != FULL) else $warning("hermes_credit_counter: credit returned to a full counter");
endmodule

// File: rtl/hermes_vc_crossbar.sv
// hermes_vc_crossbar: registered credit-based crossbar from (port, VC) input channels to output links
module hermes_vc_crossbar
  import hermes_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   req_i,
  input  flit_t            data_i [NCH],
  output logic [NCH-1:0]   ack_o,
  input  logic [NPORT-1:0] free_i,
  input  logic [CH_W-1:0]  sel_i [NPORT],
  input  logic [VC_W-1:0]  ovc_i [NPORT],
  input  logic [NPORT-1:0] credit_i,
  input  logic [VC_W-1:0]  credit_vc_i [NPORT],
  output logic [NPORT-1:0] tx_o,
  output logic [VC_W-1:0]  vc_o [NPORT],
  output flit_t            data_o [NPORT]
);
  localparam int CH_P = 1 << CH_W;
  localparam int VC_P = 1 << VC_W;
  logic [CH_P-1:0] req_p, taken;
  logic [NPORT-1:0] send;
  logic [NVC-1:0] nz [NPORT];
  logic [VC_P-1:0] nz_p [NPORT];
  // zero-padding makes out-of-range sel/ovc codes read as "no request / no credit"
  assign req_p = CH_P'(req_i);
  assign ack_o = taken[NCH-1:0];
  for (genvar o = 0; o < NPORT; o++) begin : g_out
    assign nz_p[o] = VC_P'(nz[o]);
    for (genvar v = 0; v < NVC; v++) begin : g_vc
      logic [CNT_W-1:0] count;
      logic nonzero;
      hermes_credit_counter u_cnt (
        .clk_i,
        .rst_i,
        .inc(credit_i[o] && credit_vc_i[o] == VC_W'(v)),
        .dec(send[o] && ovc_i[o] == VC_W'(v)),
        .count,
        .nonzero
      );
      assign nz[o][v] = nonzero && count != '0;
    end
  end
  // lower output indices claim a channel first; later duplicates are suppressed
  always_comb begin
    send = '0;
    taken = '0;
    for (int o = 0; o < NPORT; o++)
      if (!rst_i && !free_i[o] && req_p[sel_i[o]] && nz_p[o][ovc_i[o]] && !taken[sel_i[o]]) begin
        send[o] = 1'b1;
        taken[sel_i[o]] = 1'b1;
      end
  end
  always_ff @(posedge clk_i)
    for (int o = 0; o < NPORT; o++) begin
      tx_o[o] <= send[o];
      vc_o[o] <= send[o] ? ovc_i[o] : '0;
      data_o[o] <= send[o] ? data_i[sel_i[o]] : '0;
    end
endmodule

// File: tb/tb_hermes_vc_crossbar.sv
// tb_hermes_vc_crossbar: directed and randomized scoreboard bench for the VC crossbar
module tb_hermes_vc_crossbar;
  import hermes_pkg::*;
  typedef struct { logic [VC_W-1:0] vc; flit_t data; } ent_t;
  logic clk = 1'b0;
  logic rst_i;
  logic [NCH-1:0] req_i, ack_o;
  flit_t data_i [NCH];
  logic [NPORT-1:0] free_i, credit_i, tx_o;
  logic [CH_W-1:0] sel_i [NPORT];
  logic [VC_W-1:0] ovc_i [NPORT], credit_vc_i [NPORT], vc_o [NPORT];
  flit_t data_o [NPORT];
  ent_t expq [NPORT][$];
  int credits [NPORT][NVC];
  int ackcnt [NCH];
  int total = 0, bad = 0;
  bit mon_on = 1'b0;
  int b;

  always #5 clk = ~clk;

  hermes_vc_crossbar dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .free_i(free_i), .sel_i(sel_i), .ovc_i(ovc_i), .credit_i(credit_i),
    .credit_vc_i(credit_vc_i), .tx_o(tx_o), .vc_o(vc_o), .data_o(data_o)
  );

  always @(posedge clk) begin
    #1;
    if (mon_on)
      for (int o = 0; o < NPORT; o++) begin
        ent_t e;
        bit want;
        want = expq[o].size() != 0;
        e = '{'0, '0};
        if (want) e = expq[o].pop_front();
        total++;
        if (tx_o[o] !== want || vc_o[o] !== e.vc || data_o[o] !== e.data) begin
          bad++;
          $display("FAIL out%0d got tx=%0b vc=%0d data=%h want tx=%0b vc=%0d data=%h",
                   o, tx_o[o], vc_o[o], data_o[o], want, e.vc, e.data);
        end
      end
  end

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    logic [NCH-1:0] exp_ack;
    logic [NPORT-1:0] snd;
    #1;
    exp_ack = '0;
    snd = '0;
    for (int o = 0; o < NPORT; o++) begin
      int c = int'(sel_i[o]);
      int v = int'(ovc_i[o]);
      if (!rst_i && !free_i[o] && c < NCH && v < NVC && req_i[c] && credits[o][v] > 0 && !exp_ack[c]) begin
        snd[o] = 1'b1;
        exp_ack[c] = 1'b1;
        expq[o].push_back('{ovc_i[o], data_i[c]});
      end
    end
    total++;
    if (ack_o !== exp_ack) begin
      bad++;
      $display("FAIL ack got=%h want=%h", ack_o, exp_ack);
    end
    for (int c = 0; c < NCH; c++) ackcnt[c] += int'(ack_o[c]);
    for (int o = 0; o < NPORT; o++)
      for (int v = 0; v < NVC; v++) begin
        int n = credits[o][v] + int'(credit_i[o] && int'(credit_vc_i[o]) == v)
                - int'(snd[o] && int'(ovc_i[o]) == v);
        credits[o][v] = rst_i ? CREDITS : (n > CREDITS ? CREDITS : n);
      end
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic quiet();
    free_i = '1;
    req_i = '0;
    credit_i = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    quiet();
    for (int o = 0; o < NPORT; o++) begin
      sel_i[o] = CH_W'(2 * o);
      ovc_i[o] = '0;
      credit_vc_i[o] = '0;
      for (int v = 0; v < NVC; v++) credits[o][v] = CREDITS;
    end
    foreach (data_i[c]) begin
      data_i[c] = flit_t'(32'h1000 + c);
      ackcnt[c] = 0;
    end
    @(negedge clk);
    mon_on = 1'b1;
    free_i = '0;
    req_i = '1;
    run(2);
    rst_i = 1'b0;
    quiet();
    run(10);

    sel_i[0] = 3;
    ovc_i[0] = 0;
    free_i[0] = 1'b0;
    req_i[3] = 1'b1;
    b = ackcnt[3];
    repeat (6) begin
      data_i[3] = 32'hA5A5_0001 + flit_t'(ackcnt[3] - b);
      step();
    end
    check("burst acks", ackcnt[3] - b, 4);
    credit_i[0] = 1'b1;
    credit_vc_i[0] = 0;
    step();
    credit_i[0] = 1'b0;
    run(3);
    check("acks after one credit", ackcnt[3] - b, 5);

    b = ackcnt[3];
    req_i[3] = 1'b0;
    credit_i[0] = 1'b1;
    run(2);
    req_i[3] = 1'b1;
    step();
    credit_vc_i[0] = 1;
    step();
    credit_i[0] = 1'b0;
    run(3);
    check("vc0 acks with concurrent credits", ackcnt[3] - b, 3);
    ovc_i[0] = 1;
    run(6);
    check("vc1 acks untouched by credit", ackcnt[3] - b, 7);
    quiet();

    sel_i[2] = 5;
    sel_i[4] = 5;
    ovc_i[2] = 0;
    ovc_i[4] = 0;
    free_i[2] = 1'b0;
    free_i[4] = 1'b0;
    req_i[5] = 1'b1;
    b = ackcnt[5];
    run(3);
    free_i[2] = 1'b1;
    run(6);
    check("duplicate select acks", ackcnt[5] - b, 7);
    quiet();

    sel_i[1] = 0;
    ovc_i[1] = 0;
    free_i[1] = 1'b0;
    req_i[0] = 1'b1;
    b = ackcnt[0];
    step();
    rst_i = 1'b1;
    step();
    check("tx1 after reset", int'(tx_o[1]), 0);
    rst_i = 1'b0;
    req_i[0] = 1'b0;
    credit_i[1] = 1'b1;
    credit_vc_i[1] = 0;
    step();
    credit_i[1] = 1'b0;
    req_i[0] = 1'b1;
    run(6);
    check("acks after reset and saturated credit", ackcnt[0] - b, 5);
    quiet();

    repeat (400) begin
      rst_i = $urandom_range(0, 99) == 0;
      req_i = NCH'($urandom);
      foreach (data_i[c]) data_i[c] = $urandom;
      for (int o = 0; o < NPORT; o++) begin
        free_i[o] = $urandom_range(0, 3) == 0;
        sel_i[o] = CH_W'($urandom_range(0, (1 << CH_W) - 1));
        ovc_i[o] = VC_W'($urandom_range(0, NVC - 1));
        credit_vc_i[o] = VC_W'($urandom_range(0, NVC - 1));
        credit_i[o] = $urandom_range(0, 1) == 1 && credits[o][credit_vc_i[o]] < CREDITS;
      end
      step();
    end
    rst_i = 1'b0;
    quiet();
    run(3);
    for (int o = 0; o < NPORT; o++) check("queue drained", expq[o].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
